noc_vc_grant_arbiter: RTL
=========================

# noc_vc_grant_arbiter

Packet-level virtual-channel arbiter placed directly upstream of the VC merge stage; it produces the one-hot `vc_grant` vector that steers one VC onto the shared merge FIFO. It picks a requesting VC round-robin on a head flit and holds that grant until the packet's tail flit is accepted. Flits of different packets therefore never interleave in the merge FIFO.

## Interface
- `CHANNELS`, default `Noc_VC_Channel`: number of virtual channels (≥2).
- `LOCK_TIMEOUT`, default `Noc_VC_Lock_Timeout` (1024): watchdog limit in cycles; used only when the watchdog is compiled in.
- `noc_clk`  in  1  clock.
- `noc_rst`  in  1  asynchronous, active-high reset.
- `i_vc_valid`  in  CHANNELS  per-VC flit valid, same signal that feeds the merge stage.
- `i_vc_head`  in  CHANNELS  per-VC flit is a head flit; meaningful only when valid.
- `i_vc_tail`  in  CHANNELS  per-VC flit is a tail flit; head and tail may both be set (single-flit packet).
- `i_merge_ready`  in  1  merge FIFO accepts a flit this cycle.
- `o_vc_grant`  out  CHANNELS  one-hot or zero grant to the merge stage; registered.
- `o_grant_id`  out  $clog2(CHANNELS)  index of the granted VC; 0 when nothing is granted.
- `o_busy`  out  1  high while in LOCKED.
- `o_timeout`  out  1  one-cycle pulse on a watchdog release; tied 0 when the watchdog is compiled out.

## Operation
- State machine with two states, IDLE and LOCKED. Reset state is IDLE.
- `req[i] = i_vc_valid[i] & i_vc_head[i]`. A valid non-head flit never requests.
- `fire = |(o_vc_grant & i_vc_valid) & i_merge_ready`.
- IDLE:
  - If `|req`, select the first requesting VC searching upward from `ptr`, modulo CHANNELS.
  - Register its one-hot grant, set `ptr <= (k+1) % CHANNELS`, and go to LOCKED.
  - Otherwise stay in IDLE with grant 0.
- LOCKED:
  - Grant is held constant.
  - On `fire` with the granted VC's tail set, clear the grant and go to IDLE.
  - Fire on non-tail flits keeps the lock.
  - Loss of valid or ready mid-packet keeps the lock.
- Single-flit packet: it is granted, and its own fire releases the lock.
- `ptr` advances only when a grant is issued.
- Reset values: `o_vc_grant=0`, `o_grant_id=0`, `o_busy=0`, `o_timeout=0`, `ptr=0`, state IDLE, watchdog counter 0.
- Asserting reset mid-packet drops the grant immediately (asynchronous). The partial packet is not the arbiter's concern.

## Timing
- Grant latency: a request sampled in IDLE at cycle t gives `o_vc_grant` valid at t+1.
- Release: a tail fire at cycle t gives grant 0 at t+1 (IDLE), and the next grant earliest at t+2.
- Result: one idle bubble between packets. Each grant lasts at least one cycle.
- The first flit can transfer in the first granted cycle; `fire` is evaluated combinationally each cycle.
- All outputs come from flops. No combinational path runs from inputs to `o_vc_grant`.

## Configuration
- Macro: `NOC_VC_ARB_WATCHDOG_EN`.
- With the macro defined:
  - A counter of width $clog2(LOCK_TIMEOUT+1) increments each LOCKED cycle without `fire` and clears on every fire and in IDLE.
  - When the counter reaches LOCK_TIMEOUT, the grant is force-released to IDLE, `o_timeout` pulses for one cycle, and the counter clears.
  - `ptr` is unchanged by a forced release.
- Without the macro: no counter is built, `o_timeout` is constant 0, and a lock can be held indefinitely.

## Structure
- Package `Noc_parameters` gains:
  - `Noc_VC_Lock_Timeout` (int, 1024).
  - `typedef enum logic {ARB_IDLE, ARB_LOCKED} noc_vc_arb_state_t`.
- One combinational sub-module, `noc_rr_pick`: inputs `req[N]` and `ptr`; outputs a one-hot pick and an index. It is reusable by other arbiters in the fabric.
- The top level holds the state register, `ptr`, the grant register and the watchdog.

## Test plan
- CHANNELS=4, reset, VC2 valid head+tail with ready=1 → grant 4'b0100 one cycle after request, released next cycle, `ptr`=3.
- VCs 0 and 3 both request with `ptr`=3 → VC3 granted first. After VC3's tail fires, VC0 is granted two cycles later.
- VC1 sends a 4-flit packet while VC0 holds head valid and ready toggles 1,0,1,1,0,1 → grant stays 4'b0010 until the 4th fire. VC0 is never granted mid-packet.
- VC1 presents a valid non-head flit in IDLE → no grant, `o_busy`=0.
- Reset asserted while locked on VC2 → `o_vc_grant`=0 asynchronously and `ptr`=0. After reset release, the lowest requester is granted first.
- Watchdog: `NOC_VC_ARB_WATCHDOG_EN` defined, LOCK_TIMEOUT=8, granted VC stalls with ready=0 → `o_timeout` pulses in the cycle the count reaches 8, then grant=0 and IDLE.

Source files
------------

// File: rtl/noc_vc_grant_arbiter_pkg.sv
// Shared NoC fabric parameters and the VC grant arbiter state type.
package Noc_parameters;

   localparam int Noc_VC_Channel      = 4;
   localparam int Noc_VC_Lock_Timeout = 1024;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} noc_vc_arb_state_t;

endpackage

// File: rtl/noc_vc_grant_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo N.
module noc_rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         pick,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);

   localparam int IdxW = $clog2(N);

   logic [IdxW-1:0] pos;
   logic            found;

   assign any = |req;

   always_comb begin
      pick  = '0;
      idx   = '0;
      pos   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         pos = IdxW'((32'(ptr) + 32'(i)) % 32'(N));
         if (!found && req[pos]) begin
            found     = 1'b1;
            pick[pos] = 1'b1;
            idx       = pos;
         end
      end
   end

endmodule

// File: rtl/noc_vc_grant_arbiter.sv
// Packet-level VC arbiter: round-robin grant on a head flit, held until the tail is accepted.
// Optional lock watchdog enabled by defining NOC_VC_ARB_WATCHDOG_EN.
module noc_vc_grant_arbiter
   import Noc_parameters::*;
#(
   parameter int CHANNELS     = Noc_VC_Channel,
   parameter int LOCK_TIMEOUT = Noc_VC_Lock_Timeout
) (
   input  logic                        noc_clk,
   input  logic                        noc_rst,
   input  logic [CHANNELS-1:0]         i_vc_valid,
   input  logic [CHANNELS-1:0]         i_vc_head,
   input  logic [CHANNELS-1:0]         i_vc_tail,
   input  logic                        i_merge_ready,
   output logic [CHANNELS-1:0]         o_vc_grant,
   output logic [$clog2(CHANNELS)-1:0] o_grant_id,
   output logic                        o_busy,
   output logic                        o_timeout
);

   localparam int IdxW = $clog2(CHANNELS);

   noc_vc_arb_state_t   state_q;
   logic [CHANNELS-1:0] grant_q;
   logic [IdxW-1:0]     grant_id_q;
   logic [IdxW-1:0]     ptr_q;

   logic [CHANNELS-1:0] req;
   logic [CHANNELS-1:0] pick;
   logic [IdxW-1:0]     pick_idx;
   logic [IdxW-1:0]     next_ptr;
   logic                any_req;
   logic                fire;
   logic                tail_fire;
   logic                release_lock;

   // Only head flits open a packet; body/tail flits of an unlocked VC are ignored.
   assign req = i_vc_valid & i_vc_head;

   noc_rr_pick #(
      .N(CHANNELS)
   ) u_rr_pick (
      .req  (req),
      .ptr  (ptr_q),
      .pick (pick),
      .idx  (pick_idx),
      .any  (any_req)
   );

   assign next_ptr  = (pick_idx == IdxW'(CHANNELS - 1)) ? '0 : pick_idx + IdxW'(1);
   assign fire      = (|(grant_q & i_vc_valid)) & i_merge_ready;
   assign tail_fire = fire & (|(grant_q & i_vc_tail));

`ifdef NOC_VC_ARB_WATCHDOG_EN
   localparam int CntW = $clog2(LOCK_TIMEOUT + 1);

   logic [CntW-1:0] wd_cnt_q;
   logic            wd_expire;
   logic            timeout_q;

   // Expires on the stalled cycle that would bring the count to LOCK_TIMEOUT.
   assign wd_expire    = (state_q == ARB_LOCKED) && !fire &&
                         (wd_cnt_q == CntW'(LOCK_TIMEOUT - 1));
   assign release_lock = tail_fire | wd_expire;
   assign o_timeout    = timeout_q;
`else
   logic unused_lock_timeout;

   assign unused_lock_timeout = ^LOCK_TIMEOUT;
   assign release_lock        = tail_fire;
   assign o_timeout           = 1'b0;
`endif

   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         state_q    <= ARB_IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         ptr_q      <= '0;
`ifdef NOC_VC_ARB_WATCHDOG_EN
         wd_cnt_q   <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (any_req) begin
                  state_q    <= ARB_LOCKED;
                  grant_q    <= pick;
                  grant_id_q <= pick_idx;
                  ptr_q      <= next_ptr;
               end
            end
            ARB_LOCKED: begin
               if (release_lock) begin
                  state_q    <= ARB_IDLE;
                  grant_q    <= '0;
                  grant_id_q <= '0;
               end
            end
            default: begin
               state_q    <= ARB_IDLE;
               grant_q    <= '0;
               grant_id_q <= '0;
            end
         endcase
`ifdef NOC_VC_ARB_WATCHDOG_EN
         timeout_q <= wd_expire;
         if ((state_q == ARB_LOCKED) && !fire && !wd_expire) begin
            wd_cnt_q <= wd_cnt_q + CntW'(1);
         end else begin
            wd_cnt_q <= '0;
         end
`endif
      end
   end

   assign o_vc_grant = grant_q;
   assign o_grant_id = grant_id_q;
   assign o_busy     = (state_q == ARB_LOCKED);

endmodule
